roc_aer_tx: RTL

Transmit stage directly downstream of the rank-order-coding encoder. It consumes each sorted pixel index the encoder emits (`NEXT_INDEX` / `FOUND_NEXT_INDEX`) and drives it as one address-event onto the 4-phase AER input link of the SNN core. While an event is in flight it asserts `AERIN_CTRL_BUSY` back to the encoder, which holds off the next index. It also counts delivered events per image and flags protocol errors.

---
 rtl/roc_aer_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/roc_aer_tx.sv
// roc_aer_tx: transmit stage behind the rank-order-coding encoder.
// It takes each sorted pixel index (NEXT_INDEX / FOUND_NEXT_INDEX) and sends it
// as one address-event over a 4-phase REQ/ACK link into the SNN core. It also
// counts delivered events per image and flags protocol errors.
//
// Ports:
//   CLK, RST          single clock, synchronous active-high reset
//   NEXT_INDEX        sorted pixel index from the encoder
//   FOUND_NEXT_INDEX  1-cycle strobe, NEXT_INDEX valid
//   NEW_IMAGE         1-cycle strobe, clears EVT_CNT and sticky errors
//   AERIN_CTRL_BUSY   event in flight, encoder must hold off
//   AERIN_ADDR        AER address to the core (holds last value when idle)
//   AERIN_REQ         AER request
//   AERIN_ACK         AER acknowledge from the core
//   EVT_CNT           events completed since last NEW_IMAGE, saturating
//   DROP_ERR          sticky, a strobe arrived while busy
//   TIMEOUT_ERR       sticky, ack timeout aborted an event
//
// Build option: define ROC_AER_ACK_SYNC_EN to pass AERIN_ACK through a 2-flop
// synchronizer (core on another clock / asynchronous). Undefined, the ack
// feeds the FSM directly.
module roc_aer_tx #(
  parameter int ADDR_BITS   = 10,
  parameter int CNT_BITS    = 10,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ADDR_BITS-1:0] NEXT_INDEX,
  input  logic                 FOUND_NEXT_INDEX,
  input  logic                 NEW_IMAGE,
  output logic                 AERIN_CTRL_BUSY,
  output logic [ADDR_BITS-1:0] AERIN_ADDR,
  output logic                 AERIN_REQ,
  input  logic                 AERIN_ACK,
  output logic [CNT_BITS-1:0]  EVT_CNT,
  output logic                 DROP_ERR,
  output logic                 TIMEOUT_ERR
);

  localparam int TO_BITS = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    REQ,
    ACK_LOW
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 ack_s;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [TO_BITS-1:0]   to_cnt;
  logic                 to_hit;
  logic                 capture;
  logic                 load_addr;
  logic                 req_d;
  logic                 evt_done;
  logic                 abort;
  logic                 drop;

`ifdef ROC_AER_ACK_SYNC_EN
  logic ack_meta;
  logic ack_sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= AERIN_ACK;
      ack_sync <= ack_meta;
    end
  end

  always_comb ack_s = ack_sync;
`else
  always_comb ack_s = AERIN_ACK;
`endif

  // Counter holds k-1 at the k-th edge spent in REQ, so the abort edge leaves
  // AERIN_REQ high for exactly ACK_TIMEOUT cycles.
  always_comb to_hit = (ACK_TIMEOUT != 0) && (to_cnt == TO_BITS'(ACK_TIMEOUT));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; an ack seen on the timeout edge still wins.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (FOUND_NEXT_INDEX) next_state = LATCH;
      LATCH:   next_state = REQ;
      REQ: begin
        if (ack_s)       next_state = ACK_LOW;
        else if (to_hit) next_state = IDLE;
      end
      ACK_LOW: if (!ack_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    AERIN_CTRL_BUSY = (state != IDLE);
    capture         = (state == IDLE) && FOUND_NEXT_INDEX;
    load_addr       = (state == LATCH);
    // REQ is registered one cycle behind state entry so the address has a
    // full cycle of setup on the link before the request rises.
    req_d           = (state == REQ) && (next_state == REQ);
    evt_done        = (state == ACK_LOW) && !ack_s;
    abort           = (state == REQ) && !ack_s && to_hit;
    drop            = FOUND_NEXT_INDEX && (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_reg    <= '0;
      AERIN_ADDR  <= '0;
      AERIN_REQ   <= 1'b0;
      to_cnt      <= '0;
      EVT_CNT     <= '0;
      DROP_ERR    <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (capture)   addr_reg   <= NEXT_INDEX;
      if (load_addr) AERIN_ADDR <= addr_reg;
      AERIN_REQ <= req_d;

      if (state == REQ && ACK_TIMEOUT != 0) to_cnt <= to_cnt + TO_BITS'(1);
      else                                  to_cnt <= '0;

      // NEW_IMAGE takes priority over a same-cycle increment or error set.
      if (NEW_IMAGE) begin
        EVT_CNT     <= '0;
        DROP_ERR    <= 1'b0;
        TIMEOUT_ERR <= 1'b0;
      end else begin
        if (evt_done && EVT_CNT != '1) EVT_CNT <= EVT_CNT + CNT_BITS'(1);
        if (drop)  DROP_ERR    <= 1'b1;
        if (abort) TIMEOUT_ERR <= 1'b1;
      end
    end
  end

endmodule
